crc32_frame_ctrl: RTL and testbench
===================================

Name: crc32_frame_ctrl

Overview:
- Frame-level sequencer for the 48-bit-per-cycle combinational CRC-32 update (polynomial 0x04C11DB7, left shift, big-endian).
- Accepts a valid/ready stream of 48-bit words with start-of-frame and end-of-frame markers.
- Holds the running CRC in a register and feeds it back through one combinational update instance each accepted beat.
- Presents the finished frame CRC on a valid/ready result port. Sits between the packet framer and the transmit/check logic.

Parameters:
- CRC_INIT, 32'hFFFF_FFFF: value the CRC register is seeded with at start of frame.
- XOR_OUT, 32'hFFFF_FFFF: value XORed onto the CRC register to form crc_out.
- MAX_WORDS, 1024: frame-length limit in 48-bit words; exceeding it flags an error.
- CNT_W, 16: width of the word counter; must satisfy 2^CNT_W > MAX_WORDS.

Ports:
- clk  in  1  sole clock.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  48  data word, fed unchanged to the CRC update data input.
- in_sof  in  1  beat is the first word of a frame.
- in_eof  in  1  beat is the last word of a frame.
- crc_valid  out  1  result available.
- crc_ready  in  1  result consumer accepts.
- crc_out  out  32  frame CRC, equal to crc_reg ^ XOR_OUT.
- word_cnt  out  CNT_W  words accepted in the current or last frame.
- err_overflow  out  1  frame exceeded MAX_WORDS.
- busy  out  1  state is not IDLE.

Behaviour:
- Definitions:
  - A beat is accepted when in_valid && in_ready on a rising clk.
  - upd(c,d) is the combinational CRC-32 update of state c with word d.
- Reset (rst_n low at a clk edge, taking priority over everything else):
  - state is IDLE, crc_reg = CRC_INIT, word_cnt = 0.
  - err_overflow = 0, crc_valid = 0, busy = 0, in_ready = 1.
  - Reset mid-frame or mid-HOLD discards the frame and the pending result without any output.
- States: IDLE, RUN, HOLD.
- IDLE (in_ready=1):
  - Accepted beat with in_sof: crc_reg <= upd(CRC_INIT, in_data), word_cnt <= 1, err_overflow <= 0.
  - Next state is HOLD if in_eof is also set, otherwise RUN.
  - Accepted beat without in_sof: dropped; no state, CRC or counter change.
- RUN (in_ready=1):
  - Accepted beat without in_sof: crc_reg <= upd(crc_reg, in_data), word_cnt <= word_cnt+1 (saturating at all ones).
  - If in_eof is set, next state is HOLD.
  - Accepted beat with in_sof: the current frame is aborted and silently restarted. Update uses CRC_INIT, word_cnt <= 1, err_overflow <= 0; then the same eof handling as in IDLE.
  - in_valid low: hold all state.
- HOLD (in_ready=0):
  - crc_valid=1 and crc_out is stable.
  - On crc_ready: go to IDLE, crc_valid deasserts next cycle.
  - crc_out and word_cnt remain valid until the next sof is accepted.
- Latency:
  - crc_valid rises the cycle after the eof beat is accepted.
  - Minimum frame-to-frame spacing is one eof beat plus one HOLD cycle when crc_ready is held high.
- err_overflow:
  - Set when a beat is accepted while word_cnt == MAX_WORDS.
  - Sticky until the next accepted sof. The frame still completes and the CRC covers all words.
- in_ready is a registered function of state only. It has no combinational path from crc_ready.
- crc_out is driven from registers only (crc_reg ^ XOR_OUT).
- in_sof and in_eof are ignored when the beat is not accepted.

Optional Feature:
- Macro: CRC32_FRAME_CHECK_EN.
- When defined:
  - Adds input crc_expect[31:0], sampled with the eof beat.
  - Adds output crc_match, registered, valid while crc_valid=1, equal to (upd result ^ XOR_OUT) == crc_expect.
  - crc_match resets to 0.
- When undefined: both ports are absent and the logic is removed. Behaviour is otherwise identical.

Test Plan:
- Single-beat frame, CRC_INIT=0, XOR_OUT=0, in_data=48'h1, sof=eof=1 -> next cycle crc_valid=1, crc_out=32'h04C11DB7, word_cnt=1.
- Same parameters, in_data=0 -> crc_out=32'h0. A beat without sof while IDLE -> no crc_valid, word_cnt unchanged.
- Default parameters, 4-word frame with in_valid gaps and crc_ready held low 5 cycles -> in_ready=0 during HOLD, crc_out matches a bit-serial model of the same four words, crc_valid drops the cycle after crc_ready.
- MAX_WORDS=4, 6-word frame -> err_overflow=1 from the 5th beat, word_cnt=6, CRC covers all 6 words. The next sof clears err_overflow.
- sof arriving mid-frame after 3 words, then 2 words with eof -> CRC equals that of the 2-word frame alone, word_cnt=2. Reset pulsed during RUN -> no crc_valid, crc_reg back to CRC_INIT.
- With CRC32_FRAME_CHECK_EN, CRC_INIT=0, XOR_OUT=0, data 48'h1, crc_expect=32'h04C11DB7 -> crc_match=1. With crc_expect=32'h0 -> crc_match=0.

Source files
------------

// File: rtl/crc32_frame_ctrl.sv
// Frame sequencer around a 48-bit-per-cycle CRC-32 (poly 0x04C11DB7, MSB first, no reflection).
// Optional frame check compare port pair is enabled by defining CRC32_FRAME_CHECK_EN.
module crc32_frame_ctrl #(
  parameter logic [31:0] CRC_INIT  = 32'hFFFF_FFFF,
  parameter logic [31:0] XOR_OUT   = 32'hFFFF_FFFF,
  parameter int          MAX_WORDS = 1024,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [47:0]      in_data,
  input  logic             in_sof,
  input  logic             in_eof,
`ifdef CRC32_FRAME_CHECK_EN
  input  logic [31:0]      crc_expect,
  output logic             crc_match,
`endif
  output logic             crc_valid,
  input  logic             crc_ready,
  output logic [31:0]      crc_out,
  output logic [CNT_W-1:0] word_cnt,
  output logic             err_overflow,
  output logic             busy
);

  localparam logic [31:0] POLY = 32'h04C1_1DB7;

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t           state_reg;
  logic [31:0]      crc_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             ovf_reg;
  logic             in_ready_reg;
  logic             crc_valid_reg;
  logic             busy_reg;

  logic             accept;
  logic             load;
  logic [31:0]      crc_seed;
  logic [31:0]      crc_next;
  logic [CNT_W-1:0] cnt_inc;

  assign accept   = in_valid && in_ready_reg;
  // A sof restarts from CRC_INIT in both IDLE and RUN; non-sof beats only count in RUN.
  assign load     = accept && (in_sof || (state_reg == RUN));
  assign crc_seed = (state_reg == RUN && !in_sof) ? crc_reg : CRC_INIT;
  assign cnt_inc  = (cnt_reg == {CNT_W{1'b1}}) ? cnt_reg : cnt_reg + CNT_W'(1);

  // Unrolled bit-serial update, one stage per data bit, MSB of in_data first.
  genvar gi;
  generate
    for (gi = 0; gi < 48; gi++) begin : g_upd
      logic [31:0] prev;
      logic [31:0] nxt;
      logic        fb;
      if (gi == 0) begin : g_seed
        assign prev = crc_seed;
      end else begin : g_chain
        assign prev = g_upd[gi-1].nxt;
      end
      assign fb  = prev[31] ^ in_data[47-gi];
      assign nxt = {prev[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
    end
  endgenerate

  assign crc_next = g_upd[47].nxt;

`ifdef CRC32_FRAME_CHECK_EN
  logic match_reg;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      match_reg <= 1'b0;
    end else if (load && in_eof) begin
      match_reg <= ((crc_next ^ XOR_OUT) == crc_expect);
    end
  end
  assign crc_match = match_reg;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      crc_reg       <= CRC_INIT;
      cnt_reg       <= '0;
      ovf_reg       <= 1'b0;
      in_ready_reg  <= 1'b1;
      crc_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, RUN: begin
          if (load) begin
            crc_reg <= crc_next;
            if (in_sof) begin
              cnt_reg <= CNT_W'(1);
              ovf_reg <= 1'b0;
            end else begin
              cnt_reg <= cnt_inc;
              if (cnt_reg == CNT_W'(MAX_WORDS)) begin
                ovf_reg <= 1'b1;
              end
            end
            busy_reg <= 1'b1;
            if (in_eof) begin
              state_reg     <= HOLD;
              in_ready_reg  <= 1'b0;
              crc_valid_reg <= 1'b1;
            end else begin
              state_reg <= RUN;
            end
          end
        end
        HOLD: begin
          if (crc_ready) begin
            state_reg     <= IDLE;
            in_ready_reg  <= 1'b1;
            crc_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
          end
        end
        default: begin
          state_reg     <= IDLE;
          in_ready_reg  <= 1'b1;
          crc_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready     = in_ready_reg;
  assign crc_valid    = crc_valid_reg;
  assign busy         = busy_reg;
  assign crc_out      = crc_reg ^ XOR_OUT;
  assign word_cnt     = cnt_reg;
  assign err_overflow = ovf_reg;

endmodule

// File: tb/tb_crc32_frame_ctrl.sv
// Scoreboard bench: two instances (zero init/xor with MAX_WORDS=4, and default parameters)
// share one stimulus stream; a bit-serial model predicts each frame result.
module tb_crc32_frame_ctrl;

  localparam int MAXZ = 4;
  localparam int MAXD = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [47:0] in_data = '0;
  logic        in_sof = 1'b0;
  logic        in_eof = 1'b0;
  logic        crc_ready = 1'b0;
  logic [31:0] crc_expect = '0;

  logic        rdy_z, vld_z, ovf_z, busy_z, match_z;
  logic [31:0] crc_z;
  logic [15:0] cnt_z;
  logic        rdy_d, vld_d, ovf_d, busy_d, match_d;
  logic [31:0] crc_d;
  logic [15:0] cnt_d;

  always #5 clk = ~clk;

  crc32_frame_ctrl #(.CRC_INIT(32'h0), .XOR_OUT(32'h0), .MAX_WORDS(MAXZ), .CNT_W(16)) dut_z (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_z), .in_data(in_data),
    .in_sof(in_sof), .in_eof(in_eof),
`ifdef CRC32_FRAME_CHECK_EN
    .crc_expect(crc_expect), .crc_match(match_z),
`endif
    .crc_valid(vld_z), .crc_ready(crc_ready), .crc_out(crc_z), .word_cnt(cnt_z),
    .err_overflow(ovf_z), .busy(busy_z)
  );

  crc32_frame_ctrl #(.MAX_WORDS(MAXD)) dut_d (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_d), .in_data(in_data),
    .in_sof(in_sof), .in_eof(in_eof),
`ifdef CRC32_FRAME_CHECK_EN
    .crc_expect(crc_expect), .crc_match(match_d),
`endif
    .crc_valid(vld_d), .crc_ready(crc_ready), .crc_out(crc_d), .word_cnt(cnt_d),
    .err_overflow(ovf_d), .busy(busy_d)
  );

`ifndef CRC32_FRAME_CHECK_EN
  assign match_z = 1'b0;
  assign match_d = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [31:0] crc_z;
    logic [31:0] crc_d;
    int          cnt;
    bit          ovf_z;
    bit          ovf_d;
    bit          match_z;
    bit          match_d;
  } res_t;

  res_t sb[$];

  int          m_state = 0;  // 0 idle, 1 run, 2 hold
  logic [31:0] m_crc_z = '0;
  logic [31:0] m_crc_d = '1;
  int          m_cnt = 0;
  bit          m_ovf_z = 0, m_ovf_d = 0;
  bit          prev_vld = 0;
  int          frame_no = 0;

  function automatic logic [31:0] crc_ser(input logic [31:0] c, input logic [47:0] d);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int i = 47; i >= 0; i--) begin
      fb = r[31] ^ d[i];
      r  = r << 1;
      if (fb) r = r ^ 32'h04C11DB7;
    end
    return r;
  endfunction

  // One clock: update the model at the edge, then compare at the following falling edge.
  task automatic step();
    res_t r;
    @(posedge clk);
    if (!rst_n) begin
      m_state = 0; m_crc_z = '0; m_crc_d = '1; m_cnt = 0; m_ovf_z = 0; m_ovf_d = 0;
    end else if (m_state == 2) begin
      if (crc_ready) m_state = 0;
    end else if (in_valid && (in_sof || m_state == 1)) begin
      if (in_sof) begin
        m_crc_z = crc_ser(32'h0, in_data);
        m_crc_d = crc_ser(32'hFFFF_FFFF, in_data);
        m_cnt = 1; m_ovf_z = 0; m_ovf_d = 0;
      end else begin
        if (m_cnt == MAXZ) m_ovf_z = 1;
        if (m_cnt == MAXD) m_ovf_d = 1;
        m_crc_z = crc_ser(m_crc_z, in_data);
        m_crc_d = crc_ser(m_crc_d, in_data);
        m_cnt++;
      end
      if (in_eof) begin
        m_state = 2;
        r.crc_z = m_crc_z;
        r.crc_d = m_crc_d ^ 32'hFFFF_FFFF;
        r.cnt = m_cnt;
        r.ovf_z = m_ovf_z;
        r.ovf_d = m_ovf_d;
        r.match_z = (m_crc_z == crc_expect);
        r.match_d = ((m_crc_d ^ 32'hFFFF_FFFF) == crc_expect);
        sb.push_back(r);
      end else begin
        m_state = 1;
      end
    end
    @(negedge clk);
    check_eq("in_ready_z", rdy_z, m_state != 2);
    check_eq("in_ready_d", rdy_d, m_state != 2);
    check_eq("busy_z", busy_z, m_state != 0);
    check_eq("busy_d", busy_d, m_state != 0);
    check_eq("crc_valid_z", vld_z, m_state == 2);
    check_eq("crc_valid_d", vld_d, m_state == 2);
    check_eq("word_cnt_z", cnt_z, m_cnt);
    check_eq("word_cnt_d", cnt_d, m_cnt);
    check_eq("err_ovf_z", ovf_z, m_ovf_z);
    check_eq("err_ovf_d", ovf_d, m_ovf_d);
    if (vld_z && !prev_vld) begin
      if (sb.size() == 0) begin
        check_eq("sb_underflow", 64'd1, 64'd0);
      end else begin
        r = sb.pop_front();
        frame_no++;
        $display("frame %0d: crc_z=%08h crc_d=%08h words=%0d ovf_z=%0d match=%0d/%0d",
                 frame_no, crc_z, crc_d, cnt_z, ovf_z, r.match_z, r.match_d);
        check_eq("res_crc_z", crc_z, r.crc_z);
        check_eq("res_crc_d", crc_d, r.crc_d);
        check_eq("res_cnt", cnt_z, r.cnt);
        check_eq("res_ovf_z", ovf_z, r.ovf_z);
        check_eq("res_ovf_d", ovf_d, r.ovf_d);
`ifdef CRC32_FRAME_CHECK_EN
        check_eq("res_match_z", match_z, r.match_z);
        check_eq("res_match_d", match_d, r.match_d);
`endif
      end
    end
    prev_vld = vld_z;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
    repeat (n) step();
  endtask

  task automatic send(input logic [47:0] d, input bit sof, input bit eof);
    int tries;
    bit acc;
    tries = 0;
    acc = 0;
    in_valid = 1'b1; in_data = d; in_sof = sof; in_eof = eof;
    while (!acc && tries < 50) begin
      acc = (m_state != 2) && rst_n;
      step();
      tries++;
    end
    if (!acc) check_eq("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    check_eq("rst_crc_z", crc_z, 32'h0);
    check_eq("rst_crc_d", crc_d, 32'h0);
    crc_ready = 1'b1;

    // single-beat frames on the zero-init instance
    crc_expect = 32'h04C11DB7;
    send(48'h1, 1, 1);
    check_eq("t1_crc_const", crc_z, 32'h04C11DB7);
    check_eq("t1_cnt_const", cnt_z, 16'd1);
`ifdef CRC32_FRAME_CHECK_EN
    check_eq("t1_match", match_z, 1'b1);
`endif
    idle(2);
    crc_expect = 32'h0;
    send(48'h0, 1, 1);
    check_eq("t2_crc_const", crc_z, 32'h0);
    idle(2);
    send(48'h1, 1, 1);
`ifdef CRC32_FRAME_CHECK_EN
    check_eq("t2_nomatch", match_z, 1'b0);
`endif
    idle(2);
    send(48'hABC, 0, 0);  // no sof while idle: dropped
    idle(2);
    check_eq("stray_cnt", cnt_z, 16'd1);

    // four words with gaps, result held off for five cycles
    crc_ready = 1'b0;
    send(48'h0123_4567_89AB, 1, 0);
    idle(2);
    send(48'hFEDC_BA98_7654, 0, 0);
    idle(1);
    send(48'h5A5A_A5A5_0F0F, 0, 0);
    send(48'hFFFF_0000_1234, 0, 1);
    idle(3);
    in_valid = 1'b1; in_sof = 1'b1; in_data = 48'h77;  // offered during HOLD, must be ignored
    step(); step();
    in_valid = 1'b0; in_sof = 1'b0;
    crc_ready = 1'b1;
    step();
    check_eq("t3_valid_drop", vld_d, 1'b0);
    idle(1);

    // overflow with MAX_WORDS=4 on the zero-init instance
    send(48'h11, 1, 0);
    for (int i = 2; i <= 6; i++) begin
      send(48'(i * 48'h1_0001), 0, i == 6);
      if (i == 4) check_eq("t4_ovf_before", ovf_z, 1'b0);
      if (i == 5) check_eq("t4_ovf_at5", ovf_z, 1'b1);
    end
    check_eq("t4_cnt6", cnt_z, 16'd6);
    idle(2);
    send(48'h22, 1, 1);
    check_eq("t4_ovf_clear", ovf_z, 1'b0);
    idle(2);

    // restart by mid-frame sof
    send(48'hAAAA, 1, 0); send(48'hBBBB, 0, 0); send(48'hCCCC, 0, 0);
    send(48'h1234_5678_9ABC, 1, 0);
    send(48'hDEF0_1357_2468, 0, 1);
    check_eq("t5_crc", crc_z, crc_ser(crc_ser(32'h0, 48'h1234_5678_9ABC), 48'hDEF0_1357_2468));
    check_eq("t5_cnt", cnt_z, 16'd2);
    idle(2);

    // reset during RUN discards the frame
    send(48'h99, 1, 0); send(48'h98, 0, 0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    idle(3);
    check_eq("t6_crc_z", crc_z, 32'h0);
    check_eq("t6_cnt", cnt_z, 16'd0);

    // random frames with random gaps and result back-pressure
    for (int f = 0; f < 10; f++) begin
      int len;
      len = $urandom_range(1, 7);
      crc_expect = $urandom();
      for (int w = 0; w < len; w++) begin
        send({$urandom(), 16'($urandom())}, w == 0, w == len - 1);
        idle($urandom_range(0, 2));
      end
      crc_ready = 1'b0;
      idle($urandom_range(0, 3));
      crc_ready = 1'b1;
      idle(2);
    end

    idle(3);
    check_eq("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
